// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS-lite control blocks.
package mips_ctrl_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    // Default architectural PC after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Bytes per instruction word (sequential PC increment).
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the imem handshake,
// steers the external next-PC unit and counts retired instructions.
module fetch_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    // decode / execute
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        exec_done,
    input  logic        exec_branch,
    input  logic        exec_jmp,
    input  logic [15:0] exec_imm16,
    input  logic [25:0] exec_imm26,
    input  logic        halt_req,
    // next-PC unit (sibling instance)
    output logic [31:0] npc_pc,
    output logic [15:0] npc_imm16,
    output logic [25:0] npc_imm26,
    output logic        npc_branch,
    output logic        npc_jmp,
    input  logic [31:0] npc_next,
    // status
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  retired_reg, retired_next;
    logic         halted_reg, halted_next;
    logic         fault_reg, fault_next;

    // State register; reset is asynchronous so a pending ack is dropped at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            instr_reg   <= '0;
            retired_reg <= '0;
            halted_reg  <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            retired_reg <= retired_next;
            halted_reg  <= halted_next;
            fault_reg   <= fault_next;
        end
    end

    // Next-state and output decode. The npc controls are only live in HOLD,
    // so outside it the unit computes pc+4, which is never latched.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        retired_next = retired_reg;
        halted_next  = halted_reg;
        fault_next   = fault_reg;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        npc_imm16    = '0;
        npc_imm26    = '0;
        npc_branch   = 1'b0;
        npc_jmp      = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (imem_err) begin
                        fault_next  = 1'b1;
                        halted_next = 1'b1;
                        state_next  = HALT;
                    end else begin
                        instr_next = imem_rdata;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                npc_imm16   = exec_imm16;
                npc_imm26   = exec_imm26;
                npc_branch  = exec_done & exec_branch;
                npc_jmp     = exec_done & exec_jmp;
                if (exec_done) begin
                    pc_next      = npc_next;
                    retired_next = retired_reg + 32'd1;
                    if (halt_req) begin
                        halted_next = 1'b1;
                        state_next  = HALT;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The fetch address and npc base are the architectural PC itself, so the
    // address cannot move while a request is outstanding.
    assign imem_addr = pc_reg;
    assign npc_pc    = pc_reg;
    assign instr_pc  = pc_reg;
    assign instr     = instr_reg;
    assign retired   = retired_reg;
    assign halted    = halted_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl, with a behavioural npc unit.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        exec_done = 1'b0;
    logic        exec_branch = 1'b0;
    logic        exec_jmp = 1'b0;
    logic [15:0] exec_imm16 = '0;
    logic [25:0] exec_imm26 = '0;
    logic        halt_req = 1'b0;
    logic [31:0] npc_pc;
    logic [15:0] npc_imm16;
    logic [25:0] npc_imm26;
    logic        npc_branch;
    logic        npc_jmp;
    logic [31:0] npc_next;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .exec_done(exec_done), .exec_branch(exec_branch), .exec_jmp(exec_jmp),
        .exec_imm16(exec_imm16), .exec_imm26(exec_imm26), .halt_req(halt_req),
        .npc_pc(npc_pc), .npc_imm16(npc_imm16), .npc_imm26(npc_imm26),
        .npc_branch(npc_branch), .npc_jmp(npc_jmp), .npc_next(npc_next),
        .halted(halted), .fault(fault), .retired(retired)
    );

    // Sibling next-PC unit: jump beats branch, otherwise pc+4.
    always_comb begin
        npc_next = npc_pc + 32'd4;
        if (npc_jmp)
            npc_next = {npc_pc[31:28], npc_imm26, 2'b00};
        else if (npc_branch)
            npc_next = npc_pc + 32'd4 + {{14{npc_imm16[15]}}, npc_imm16, 2'b00};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in REQ; ack after 'waits' empty cycles; leaves in HOLD.
    task automatic fetch(input int waits, input logic [31:0] data, input logic [31:0] addr);
        for (int i = 0; i < waits; i++) begin
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, addr);
            tick();
        end
        check("req", {31'd0, imem_req}, 32'd1);
        check("addr", imem_addr, addr);
        imem_ack = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        check("instr", instr, data);
        check("instr_pc", instr_pc, addr);
        check("instr_valid", {31'd0, instr_valid}, 32'd1);
        $display("fetch  addr=%h waits=%0d instr=%h", addr, waits, instr);
    endtask

    // Entered in HOLD; retires the instruction and checks the following PC.
    task automatic retire(input logic br, input logic jp, input logic [15:0] i16,
                          input logic [25:0] i26, input logic hlt, input logic [31:0] exp_pc);
        exec_done = 1'b1; exec_branch = br; exec_jmp = jp;
        exec_imm16 = i16; exec_imm26 = i26; halt_req = hlt;
        #1;
        check("npc_branch", {31'd0, npc_branch}, {31'd0, br});
        check("npc_jmp", {31'd0, npc_jmp}, {31'd0, jp});
        check("npc_imm16", {16'd0, npc_imm16}, {16'd0, i16});
        tick();
        exec_done = 1'b0; exec_branch = 1'b0; exec_jmp = 1'b0;
        exec_imm16 = '0; exec_imm26 = '0; halt_req = 1'b0;
        check("next_pc", imem_addr, exp_pc);
        check("valid_drop", {31'd0, instr_valid}, 32'd0);
        $display("retire br=%0b jmp=%0b halt=%0b -> pc=%h retired=%0d", br, jp, hlt, imem_addr, retired);
    endtask

    task automatic check_reset_values();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_3000);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_npc_jmp", {31'd0, npc_jmp}, 32'd0);
        check("rst_npc_imm26", {6'd0, npc_imm26}, 32'd0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check_reset_values();
        $display("reset  pc=%h", imem_addr);
        release_reset();

        // Straight-line fetch, then branch back at 0x3008
        fetch(0, 32'h1111_0001, 32'h0000_3000);
        retire(1'b0, 1'b0, 16'h0, 26'h0, 1'b0, 32'h0000_3004);
        fetch(0, 32'h1111_0002, 32'h0000_3004);
        retire(1'b0, 1'b0, 16'h0, 26'h0, 1'b0, 32'h0000_3008);
        fetch(0, 32'h1111_0003, 32'h0000_3008);
        retire(1'b1, 1'b0, 16'hFFFE, 26'h0, 1'b0, 32'h0000_3004);
        check("retired3", retired, 32'd3);

        // Three wait states, then a jump
        fetch(3, 32'h2222_0004, 32'h0000_3004);
        retire(1'b0, 1'b1, 16'h0, 26'h000_0C10, 1'b0, 32'h0000_3040);

        // exec_* outside HOLD must not reach npc or the PC
        exec_done = 1'b1; exec_branch = 1'b1; exec_jmp = 1'b1;
        exec_imm16 = 16'h1234; exec_imm26 = 26'h3FF_FFFF;
        #1;
        check("req_npc_br", {31'd0, npc_branch}, 32'd0);
        check("req_npc_jmp", {31'd0, npc_jmp}, 32'd0);
        check("req_npc_imm26", {6'd0, npc_imm26}, 32'd0);
        tick();
        exec_done = 1'b0; exec_branch = 1'b0; exec_jmp = 1'b0;
        exec_imm16 = '0; exec_imm26 = '0;
        check("req_pc_hold", imem_addr, 32'h0000_3040);
        check("req_retired", retired, 32'd4);

        // Jump and branch together: jump wins
        fetch(0, 32'h3333_0005, 32'h0000_3040);
        retire(1'b1, 1'b1, 16'h0010, 26'h000_0C10, 1'b0, 32'h0000_3040);
        check("retired5", retired, 32'd5);

        // Reset in the middle of a REQ wait with an ack arriving
        tick();
        #2;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        tick();
        check("rst_ack_drop", instr, 32'd0);
        imem_ack = 1'b0;
        $display("midreset pc=%h instr=%h", imem_addr, instr);
        release_reset();

        // Halting instruction at 0x3000 is counted
        fetch(0, 32'h4444_0001, 32'h0000_3000);
        retire(1'b0, 1'b0, 16'h0, 26'h0, 1'b1, 32'h0000_3004);
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_retired", retired, 32'd1);
        check("halt_fault", {31'd0, fault}, 32'd0);
        imem_ack = 1'b1; imem_err = 1'b1; exec_done = 1'b1;
        tick(); tick();
        imem_ack = 1'b0; imem_err = 1'b0; exec_done = 1'b0;
        check("halt_req_low", {31'd0, imem_req}, 32'd0);
        check("halt_pc", imem_addr, 32'h0000_3004);
        check("halt_retired2", retired, 32'd1);
        check("halt_fault2", {31'd0, fault}, 32'd0);

        // Fetch error at 0x3004
        rst_n = 1'b0;
        tick();
        release_reset();
        fetch(0, 32'h5555_0001, 32'h0000_3000);
        retire(1'b0, 1'b0, 16'h0, 26'h0, 1'b0, 32'h0000_3004);
        imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'hEEEE_EEEE;
        tick();
        imem_ack = 1'b0; imem_err = 1'b0;
        check("err_halted", {31'd0, halted}, 32'd1);
        check("err_fault", {31'd0, fault}, 32'd1);
        check("err_retired", retired, 32'd1);
        check("err_instr", instr, 32'h5555_0001);
        check("err_req", {31'd0, imem_req}, 32'd0);
        tick(); tick();
        check("err_req_stay", {31'd0, imem_req}, 32'd0);
        check("err_pc", imem_addr, 32'h0000_3004);
        $display("error  halted=%0b fault=%0b retired=%0d", halted, fault, retired);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
